// File: rtl/gpia_pkg.sv
// Shared constants for the GPIA Wishbone controller: port width, bit-bank
// mode encodings, read address map and bus handshake states.
package gpia_pkg;

  localparam int unsigned GPIA_W = 16;

  typedef enum logic [1:0] {
    MODE_WR  = 2'd0,
    MODE_SET = 2'd1,
    MODE_CLR = 2'd2,
    MODE_TGL = 2'd3
  } gpia_mode_e;

  typedef enum logic [1:0] {
    ADR_Q        = 2'd0,
    ADR_SYNC     = 2'd1,
    ADR_EDGE     = 2'd2,
    ADR_EDGE_CLR = 2'd3
  } gpia_adr_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } gpia_bus_state_e;

  // Byte-lane select expanded to a per-bit strobe mask.
  function automatic logic [GPIA_W-1:0] sel_to_mask(input logic [1:0] sel);
    return {{8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpia_wb_ctrl_if.sv
// Wishbone slave-side bundle for gpia_wb_ctrl. Signal names keep the
// controller's point of view (_i driven by the master, _o by the slave).
interface gpia_wb_ctrl_if;

  logic                        cyc_i;
  logic                        stb_i;
  logic                        we_i;
  logic [1:0]                  adr_i;
  logic [gpia_pkg::GPIA_W-1:0] dat_i;
  logic [1:0]                  sel_i;
  logic [gpia_pkg::GPIA_W-1:0] dat_o;
  logic                        ack_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o
  );

endinterface

// File: rtl/gpia_sync.sv
// Two-flop synchronizer for the asynchronous GPIA inputs plus a per-bit
// rising-edge detect on the synchronized value.
module gpia_sync
  import gpia_pkg::*;
(
  input  logic              clk_i,
  input  logic              res_i,
  input  logic [GPIA_W-1:0] inp_i,
  output logic [GPIA_W-1:0] sync_o,
  output logic [GPIA_W-1:0] rise_o
);

  logic [GPIA_W-1:0] meta_q;
  logic [GPIA_W-1:0] sync_q;
  logic [GPIA_W-1:0] prev_q;

  // Synchronizer chain; prev_q holds last cycle's synchronized value.
  always_ff @(posedge clk_i) begin
    if (!res_i) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= inp_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/gpia_wb_ctrl.sv
// Wishbone register front end for a GPIA_BIT bank: write requests become
// one-cycle mode/data/strobe commands, reads return bank state, synchronized
// inputs or the sticky edge latch.
// Optional feature macro: GPIA_EDGE_CAPTURE_EN (edge latch present).
module gpia_wb_ctrl
  import gpia_pkg::*;
(
  input  logic              clk_i,
  input  logic              res_i,
  gpia_wb_ctrl_if.slave     wb,
  output logic [1:0]        mode_o,
  output logic [GPIA_W-1:0] d_o,
  output logic [GPIA_W-1:0] stb_o,
  input  logic [GPIA_W-1:0] q_i,
  input  logic [GPIA_W-1:0] inp_i
);

  gpia_bus_state_e   state_q;
  logic [1:0]        mode_q;
  logic [GPIA_W-1:0] d_q;
  logic [GPIA_W-1:0] stb_q;
  logic [GPIA_W-1:0] dat_q;
  logic [GPIA_W-1:0] dat_d;
  logic [GPIA_W-1:0] sync_in;
  logic [GPIA_W-1:0] rise;
  logic [GPIA_W-1:0] edge_rd;
  logic              req;
  logic              rd_clr;

  gpia_sync u_sync (
    .clk_i  (clk_i),
    .res_i  (res_i),
    .inp_i  (inp_i),
    .sync_o (sync_in),
    .rise_o (rise)
  );

  // The ack cycle blocks a new request, so held strobes ack every other cycle.
  assign req    = wb.cyc_i & wb.stb_i & (state_q == ST_IDLE);
  assign rd_clr = req & ~wb.we_i & (wb.adr_i == ADR_EDGE_CLR);

`ifdef GPIA_EDGE_CAPTURE_EN
  logic [GPIA_W-1:0] edge_q;
  logic [GPIA_W-1:0] edge_d;

  // Clearing happens at the request edge so the latch reads zero during the
  // ack cycle; an edge detected on that same edge is ORed in afterwards.
  always_comb begin
    edge_d = edge_q;
    if (rd_clr) edge_d = '0;
    edge_d = edge_d | rise;
  end

  // Sticky edge latch.
  always_ff @(posedge clk_i) begin
    if (!res_i) edge_q <= '0;
    else        edge_q <= edge_d;
  end

  assign edge_rd = edge_q;
`else
  logic unused_edge;
  assign unused_edge = ^{rise, rd_clr};
  assign edge_rd     = '0;
`endif

  // Read data selection by register address.
  always_comb begin
    dat_d = '0;
    unique case (wb.adr_i)
      ADR_Q:        dat_d = q_i;
      ADR_SYNC:     dat_d = sync_in;
      ADR_EDGE:     dat_d = edge_rd;
      ADR_EDGE_CLR: dat_d = edge_rd;
      default:      dat_d = '0;
    endcase
  end

  // Handshake FSM with registered bus and bit-bank outputs.
  always_ff @(posedge clk_i) begin
    if (!res_i) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      d_q     <= '0;
      stb_q   <= '0;
      dat_q   <= '0;
    end else begin
      stb_q <= '0;
      dat_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q <= ST_ACK;
            if (wb.we_i) begin
              mode_q <= wb.adr_i;
              d_q    <= wb.dat_i;
              stb_q  <= sel_to_mask(wb.sel_i);
            end else begin
              dat_q  <= dat_d;
            end
          end
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb.ack_o = (state_q == ST_ACK);
  assign wb.dat_o = dat_q;
  assign mode_o   = mode_q;
  assign d_o      = d_q;
  assign stb_o    = stb_q;

endmodule

// File: tb/tb_gpia_wb_ctrl.sv
// Self-checking bench for gpia_wb_ctrl: directed scenarios followed by a
// randomized run compared cycle by cycle against a behavioural model.
module tb_gpia_wb_ctrl;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic [15:0] q = '0;
  logic [15:0] inp = '0;
  logic [1:0]  mode;
  logic [15:0] d;
  logic [15:0] stbv;

  gpia_wb_ctrl_if wb ();

  gpia_wb_ctrl dut (
    .clk_i  (clk),
    .res_i  (res_n),
    .wb     (wb),
    .mode_o (mode),
    .d_o    (d),
    .stb_o  (stbv),
    .q_i    (q),
    .inp_i  (inp)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  logic        m_ack;
  logic [1:0]  m_mode;
  logic [15:0] m_d, m_stb, m_dat, m_edge;
  logic [15:0] hist[$];

`ifdef GPIA_EDGE_CAPTURE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  // Advance the model by one rising edge from the currently driven inputs,
  // then let the edge happen and settle.
  task automatic tick();
    logic        rq;
    logic [15:0] sync_now, rise;
    if (!res_n) begin
      m_ack = 0; m_mode = 0; m_d = 0; m_stb = 0; m_dat = 0; m_edge = 0;
      hist.delete();
      repeat (3) hist.push_back(16'h0);
    end else begin
      rq = wb.cyc_i && wb.stb_i && !m_ack;
      sync_now = hist[1];           // input value sampled two edges earlier
      rise = hist[1] & ~hist[0];
      m_stb = 0;
      m_dat = 0;
      if (rq && wb.we_i) begin
        m_mode = wb.adr_i;
        m_d    = wb.dat_i;
        for (int b = 0; b < 16; b++) m_stb[b] = wb.sel_i[b/8];
      end
      if (rq && !wb.we_i) begin
        case (wb.adr_i)
          2'd0: m_dat = q;
          2'd1: m_dat = sync_now;
          default: m_dat = EDGE_EN ? m_edge : 16'h0;
        endcase
      end
      if (EDGE_EN) begin
        if (rq && !wb.we_i && wb.adr_i == 2'd3) m_edge = rise;
        else m_edge = m_edge | rise;
      end
      m_ack = rq;
      hist.push_back(inp);
      void'(hist.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  // Present one request for one sampled edge, then return the bus to idle.
  task automatic bus_req(input logic we, input logic [1:0] adr,
                         input logic [15:0] dat, input logic [1:0] sel);
    wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = we;
    wb.adr_i = adr; wb.dat_i = dat; wb.sel_i = sel;
    tick();
    wb.cyc_i = 0; wb.stb_i = 0;
  endtask

  task automatic test_reset();
    res_n = 0;
    tick(); tick();
    res_n = 1;
    tick();
    n_chk++; if (wb.ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", wb.ack_o); end
    n_chk++; if (stbv !== 16'h0) begin n_fail++; $display("FAIL reset_stb: got %h expected 0000", stbv); end
    n_chk++; if (mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    n_chk++; if (d !== 16'h0) begin n_fail++; $display("FAIL reset_d: got %h expected 0000", d); end
    n_chk++; if (wb.dat_o !== 16'h0) begin n_fail++; $display("FAIL reset_dat: got %h expected 0000", wb.dat_o); end
  endtask

  task automatic test_write();
    bus_req(1'b1, 2'd1, 16'h00F0, 2'b11);
    n_chk++; if (wb.ack_o !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b expected 1", wb.ack_o); end
    n_chk++; if (mode !== 2'd1) begin n_fail++; $display("FAIL wr_mode: got %0d expected 1", mode); end
    n_chk++; if (d !== 16'h00F0) begin n_fail++; $display("FAIL wr_d: got %h expected 00f0", d); end
    n_chk++; if (stbv !== 16'hFFFF) begin n_fail++; $display("FAIL wr_stb: got %h expected ffff", stbv); end
    tick();
    n_chk++; if (stbv !== 16'h0) begin n_fail++; $display("FAIL wr_stb_after: got %h expected 0000", stbv); end
    n_chk++; if (wb.ack_o !== 1'b0) begin n_fail++; $display("FAIL wr_ack_after: got %b expected 0", wb.ack_o); end
    n_chk++; if (mode !== 2'd1) begin n_fail++; $display("FAIL wr_mode_hold: got %0d expected 1", mode); end
  endtask

  task automatic test_write_read();
    bus_req(1'b1, 2'd3, 16'hFFFF, 2'b10);
    n_chk++; if (stbv !== 16'hFF00) begin n_fail++; $display("FAIL wr_hi_stb: got %h expected ff00", stbv); end
    n_chk++; if (mode !== 2'd3) begin n_fail++; $display("FAIL wr_hi_mode: got %0d expected 3", mode); end
    tick();
    q = 16'hA500;
    bus_req(1'b0, 2'd0, 16'h0, 2'b00);
    n_chk++; if (wb.ack_o !== 1'b1) begin n_fail++; $display("FAIL rd_q_ack: got %b expected 1", wb.ack_o); end
    n_chk++; if (wb.dat_o !== 16'hA500) begin n_fail++; $display("FAIL rd_q_dat: got %h expected a500", wb.dat_o); end
    n_chk++; if (stbv !== 16'h0) begin n_fail++; $display("FAIL rd_q_stb: got %h expected 0000", stbv); end
    tick();
    n_chk++; if (wb.dat_o !== 16'h0) begin n_fail++; $display("FAIL rd_dat_idle: got %h expected 0000", wb.dat_o); end
  endtask

  task automatic test_sel_zero();
    bus_req(1'b1, 2'd2, 16'h5A5A, 2'b00);
    n_chk++; if (wb.ack_o !== 1'b1) begin n_fail++; $display("FAIL sel0_ack: got %b expected 1", wb.ack_o); end
    n_chk++; if (stbv !== 16'h0) begin n_fail++; $display("FAIL sel0_stb: got %h expected 0000", stbv); end
    n_chk++; if (d !== 16'h5A5A) begin n_fail++; $display("FAIL sel0_d: got %h expected 5a5a", d); end
    tick();
  endtask

  task automatic test_sync_edge();
    logic [15:0] exp_e;
    exp_e = EDGE_EN ? 16'h0001 : 16'h0000;
    inp = 16'h0;
    tick(); tick(); tick();
    inp = 16'h0001;
    tick(); tick();
    bus_req(1'b0, 2'd1, 16'h0, 2'b00);
    n_chk++; if (wb.dat_o !== 16'h0001) begin n_fail++; $display("FAIL rd_sync: got %h expected 0001", wb.dat_o); end
    tick();
    bus_req(1'b0, 2'd2, 16'h0, 2'b00);
    n_chk++; if (wb.dat_o !== exp_e) begin n_fail++; $display("FAIL rd_edge: got %h expected %h", wb.dat_o, exp_e); end
    tick();
    bus_req(1'b0, 2'd3, 16'h0, 2'b00);
    n_chk++; if (wb.dat_o !== exp_e) begin n_fail++; $display("FAIL rd_edge_clr: got %h expected %h", wb.dat_o, exp_e); end
    tick();
    bus_req(1'b0, 2'd2, 16'h0, 2'b00);
    n_chk++; if (wb.dat_o !== 16'h0) begin n_fail++; $display("FAIL rd_edge_cleared: got %h expected 0000", wb.dat_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] pat;
    int unsigned pulses;
    pulses = 0;
    pat[4] = wb.ack_o;
    wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = 1;
    wb.adr_i = 2'd2; wb.dat_i = 16'h1234; wb.sel_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      pat[3-i] = wb.ack_o;
      if (stbv !== 16'h0) pulses++;
    end
    wb.cyc_i = 0; wb.stb_i = 0;
    n_chk++; if (pat !== 5'b01010) begin n_fail++; $display("FAIL b2b_ack_pattern: got %b expected 01010", pat); end
    n_chk++; if (pulses != 2) begin n_fail++; $display("FAIL b2b_stb_pulses: got %0d expected 2", pulses); end
    tick();
  endtask

  task automatic test_reset_abort();
    inp = 16'h0;
    tick(); tick(); tick();
    wb.cyc_i = 1; wb.stb_i = 1; wb.we_i = 1;
    wb.adr_i = 2'd1; wb.dat_i = 16'hFFFF; wb.sel_i = 2'b11;
    res_n = 0;
    tick();
    n_chk++; if (wb.ack_o !== 1'b0) begin n_fail++; $display("FAIL abort_ack: got %b expected 0", wb.ack_o); end
    n_chk++; if (stbv !== 16'h0) begin n_fail++; $display("FAIL abort_stb: got %h expected 0000", stbv); end
    res_n = 1; wb.cyc_i = 0; wb.stb_i = 0;
    tick();
    n_chk++; if (wb.ack_o !== 1'b0) begin n_fail++; $display("FAIL abort_ack_late: got %b expected 0", wb.ack_o); end
    n_chk++; if (stbv !== 16'h0) begin n_fail++; $display("FAIL abort_stb_late: got %h expected 0000", stbv); end
    bus_req(1'b1, 2'd2, 16'h0F0F, 2'b11);
    res_n = 0;
    tick();
    n_chk++; if (wb.ack_o !== 1'b0) begin n_fail++; $display("FAIL abort2_ack: got %b expected 0", wb.ack_o); end
    n_chk++; if (mode !== 2'd0) begin n_fail++; $display("FAIL abort2_mode: got %0d expected 0", mode); end
    res_n = 1;
    tick();
    bus_req(1'b0, 2'd3, 16'h0, 2'b00);
    n_chk++; if (wb.dat_o !== 16'h0) begin n_fail++; $display("FAIL abort_rd_edge: got %h expected 0000", wb.dat_o); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      res_n    = ($urandom_range(0, 39) != 0);
      wb.cyc_i = ($urandom_range(0, 3) != 0);
      wb.stb_i = ($urandom_range(0, 3) != 0);
      wb.we_i  = $urandom_range(0, 1);
      wb.adr_i = 2'($urandom_range(0, 3));
      wb.dat_i = 16'($urandom);
      wb.sel_i = 2'($urandom_range(0, 3));
      q        = 16'($urandom);
      if ($urandom_range(0, 3) == 0) inp = 16'($urandom);
      tick();
      n_chk++; if (wb.ack_o !== m_ack) begin n_fail++; $display("FAIL rnd_ack @%0d: got %b expected %b", n, wb.ack_o, m_ack); end
      n_chk++; if (stbv !== m_stb) begin n_fail++; $display("FAIL rnd_stb @%0d: got %h expected %h", n, stbv, m_stb); end
      n_chk++; if (mode !== m_mode) begin n_fail++; $display("FAIL rnd_mode @%0d: got %0d expected %0d", n, mode, m_mode); end
      n_chk++; if (d !== m_d) begin n_fail++; $display("FAIL rnd_d @%0d: got %h expected %h", n, d, m_d); end
      n_chk++; if (wb.dat_o !== m_dat) begin n_fail++; $display("FAIL rnd_dat @%0d: got %h expected %h", n, wb.dat_o, m_dat); end
    end
    wb.cyc_i = 0; wb.stb_i = 0; res_n = 1;
    tick();
  endtask

  initial begin
    wb.cyc_i = 0; wb.stb_i = 0; wb.we_i = 0;
    wb.adr_i = '0; wb.dat_i = '0; wb.sel_i = '0;
    m_ack = 0; m_mode = 0; m_d = 0; m_stb = 0; m_dat = 0; m_edge = 0;
    repeat (3) hist.push_back(16'h0);
    test_reset();
    test_write();
    test_write_read();
    test_sel_zero();
    test_sync_edge();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpia_wb_ctrl.md
GPIA_WB_CTRL -- requirements
Module: gpia_wb_ctrl

Interface
REQ-001 Parameters: none; port width fixed at 16 bits.
REQ-002 clk_i  in  1  system clock; all state changes on its rising edge.
REQ-003 res_i  in  1  reset; synchronous, active-low.
REQ-004 cyc_i, stb_i, we_i  in  1 each  Wishbone cycle, strobe, write-enable.
REQ-005 adr_i  in  2  register select; dat_i  in  16  write data; sel_i  in  2  byte lanes (bit0 = [7:0], bit1 = [15:8]).
REQ-006 dat_o  out  16  read data; ack_o  out  1  transfer acknowledge.
REQ-007 mode_o  out  2  to GPIA_BIT bank (0 write, 1 set, 2 clr, 3 tgl); d_o  out  16  per-bit data; stb_o  out  16  per-bit strobe.
REQ-008 q_i  in  16  current GPIA_BIT outputs; inp_i  in  16  asynchronous external inputs.

Function
REQ-009 Request = cyc_i & stb_i & ~ack_o, sampled at a rising edge; ack_o SHALL go high the next cycle for exactly one cycle.
REQ-010 Back-to-back requests SHALL ack on alternate cycles; no request is lost or double-acked.
REQ-011 Write request: mode_o <= adr_i, d_o <= dat_i, stb_o[7:0] <= {8{sel_i[0]}}, stb_o[15:8] <= {8{sel_i[1]}}, all registered and valid in the ack_o cycle only.
REQ-012 stb_o SHALL be 16'h0000 in every cycle not carrying a write ack; mode_o and d_o hold their last value.
REQ-013 GPIA_BIT update follows one cycle after ack_o; total write-to-q latency 2 cycles from request sample.
REQ-014 Read request: dat_o registered, valid in ack_o cycle; adr 0 = q_i, 1 = sync_in, 2 = edge latch, 3 = edge latch with clear; dat_o = 0 outside ack cycles.
REQ-015 inp_i SHALL pass a 2-flop synchronizer to sync_in; sync_in lags inp_i by 2 cycles.
REQ-016 Rising edge on sync_in bit n (previous 0, current 1) SHALL set edge latch bit n; bits are sticky.
REQ-017 Read of adr 3 SHALL clear edge latch in the ack cycle; a new edge in the same cycle SHALL win (bit remains set), and dat_o returns the pre-clear value.
REQ-018 Reads SHALL never assert stb_o; writes SHALL never alter the edge latch.
REQ-019 sel_i = 2'b00 write SHALL ack normally with stb_o = 0.

Reset
REQ-020 While res_i = 0 at a clock edge: ack_o = 0, stb_o = 0, mode_o = 0, d_o = 0, dat_o = 0, synchronizer flops = 0, edge latch = 0.
REQ-021 Reset mid-transfer SHALL abort it: no ack_o and no stb_o pulse for that request afterwards.
REQ-022 First request may be sampled on the first edge with res_i = 1.

Configuration
REQ-023 Macro GPIA_EDGE_CAPTURE_EN defined: edge latch per REQ-016/017.
REQ-024 Macro GPIA_EDGE_CAPTURE_EN undefined: no edge-latch flops; reads of adr 2 and 3 return 16'h0000; all else unchanged.

Structure
REQ-025 Package gpia_pkg SHALL hold mode encodings (MODE_WR, MODE_SET, MODE_CLR, MODE_TGL), read address constants, and port width constant (16).
REQ-026 Sub-module gpia_sync SHALL implement the 2-flop synchronizer and rising-edge detect per bit; gpia_wb_ctrl instantiates it once.

Verification
REQ-027 Reset held 2 cycles, then released -> all outputs 0, ack_o low with no request.
REQ-028 Write adr 1, dat_i 16'h00F0, sel_i 2'b11 -> ack_o one cycle, same cycle mode_o 1, d_o 16'h00F0, stb_o 16'hFFFF; next cycle stb_o 0.
REQ-029 Write adr 3, sel_i 2'b10, dat_i 16'hFFFF -> stb_o 16'hFF00, mode_o 3; then read adr 0 with q_i 16'hA500 -> dat_o 16'hA500.
REQ-030 inp_i 0 -> 16'h0001 at cycle T -> sync_in read = 1 from T+2; read adr 2 -> 16'h0001; read adr 3 -> 16'h0001; read adr 2 -> 16'h0000.
REQ-031 cyc_i & stb_i held high 4 cycles -> ack_o pattern 0,1,0,1; exactly two stb_o pulses for writes.
REQ-032 res_i low in cycle between request sample and ack -> no ack_o, stb_o stays 0; with GPIA_EDGE_CAPTURE_EN undefined, read adr 3 -> 16'h0000.
